riscv_core_amo_sequencer: RTL
=============================

RISCV_CORE_AMO_SEQUENCER -- requirements
Module: riscv_core_amo_sequencer

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data and address width of the block.
REQ-002 i_clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 i_rst  in  1  SHALL be an asynchronous, active-high reset.
REQ-004 i_start  in  1  SHALL request a new atomic operation; sampled only in IDLE.
REQ-005 i_amo  in  1  SHALL mark a read-modify-write AMO operation.
REQ-006 i_amo_op  in  4  SHALL select the AMO function: 0 SWAP, 1 ADD, 2 XOR, 3 AND, 4 OR, 5 MIN, 6 MAX, 7 MINU, 8 MAXU; codes 9-15 SHALL behave as SWAP.
REQ-007 i_lr / i_sc  in  1 each  SHALL mark LR / SC; at most one of i_amo, i_lr, i_sc SHALL be high with i_start.
REQ-008 i_addr  in  XLEN  SHALL carry the effective address; i_rs2  in  XLEN  SHALL carry the store/operand value.
REQ-009 i_resv_clr  in  1  SHALL invalidate the reservation (trap, xRET, context switch).
REQ-010 o_mem_req, o_mem_we  out  1 each; o_mem_addr, o_mem_wdata  out  XLEN  SHALL form the memory request.
REQ-011 i_mem_ack  in  1; i_mem_rdata  in  XLEN  SHALL complete a request; i_mem_rdata is valid in the i_mem_ack cycle.
REQ-012 o_busy  out  1  SHALL be high from the cycle after start acceptance until the cycle after o_done, and SHALL drive pipeline stall.
REQ-013 o_done  out  1  SHALL pulse for exactly one cycle per accepted operation; o_rd_data  out  XLEN  SHALL be valid while o_done is high.
REQ-014 o_misaligned  out  1  SHALL be valid with o_done.

Function
REQ-015 The FSM SHALL have states IDLE, RD, WR, DONE.
REQ-016 IDLE SHALL capture op, operands and address when i_start is high, then move to RD (AMO/LR) or to WR or DONE (SC) on the next edge.
REQ-017 If i_addr[1:0] != 0 at start, the block SHALL go straight to DONE: no memory access, o_misaligned=1, o_rd_data=0, reservation unchanged.
REQ-018 RD SHALL hold o_mem_req=1, o_mem_we=0, o_mem_addr=captured address until i_mem_ack.
REQ-019 On the RD ack, the block SHALL latch i_mem_rdata as old value.
  - LR: SHALL set reservation valid with the captured address, then go to DONE.
  - AMO: SHALL go to WR.
REQ-020 WR SHALL hold o_mem_req=1, o_mem_we=1 until i_mem_ack.
  - AMO: o_mem_wdata = f(old, rs2).
  - SC: o_mem_wdata = rs2.
REQ-021 AMO arithmetic SHALL be modulo 2^XLEN. MIN/MAX SHALL compare signed and MINU/MAXU unsigned; on equal operands either value is correct.
REQ-022 o_mem_addr, o_mem_we and o_mem_wdata SHALL stay stable while o_mem_req is high and not acked; an ack in the first request cycle SHALL be accepted.
REQ-023 SC success (reservation valid and address[XLEN-1:2] match) SHALL go to WR, then DONE with o_rd_data=0.
REQ-024 SC failure SHALL go to DONE with o_rd_data=1 and no memory request.
REQ-025 Every SC, success or failure, SHALL clear the reservation at its completion.
REQ-026 AMO o_rd_data SHALL equal old value; LR o_rd_data SHALL equal the loaded value.
REQ-027 DONE SHALL last one cycle with o_done=1, then return to IDLE; i_start in DONE SHALL be ignored.
REQ-028 i_resv_clr SHALL clear the reservation in any state.
  - If asserted in the same cycle as an LR RD ack, the clear SHALL win.
  - An SC already in WR SHALL still complete as success.
REQ-029 Minimum latency (ack in first request cycle): start accepted at cycle 0 -> o_done at cycle 3 for AMO, cycle 2 for LR/SC success, cycle 1 for SC failure or misaligned.
REQ-030 o_mem_req SHALL never be high in IDLE or DONE.

Reset
REQ-031 On i_rst high, asynchronously and without waiting for a clock, the block SHALL apply:
  - state=IDLE;
  - reservation invalid;
  - o_mem_req=0, o_mem_we=0, o_done=0, o_busy=0, o_misaligned=0;
  - o_mem_addr=0, o_mem_wdata=0, o_rd_data=0.
REQ-032 A reset during RD or WR SHALL abandon the transaction; a late i_mem_ack after reset SHALL be ignored in IDLE.

Verification
REQ-033 AMOADD, addr 0x100, rs2=5, mem=0xFFFFFFFE, ack each first cycle -> read@0x100, write 0x00000003, o_rd_data=0xFFFFFFFE, o_done at cycle 3.
REQ-034 AMOMIN rs2=0x00000001 with mem=0x80000000 -> write 0x80000000; AMOMINU with the same values -> write 0x00000001.
REQ-035 LR 0x200 then SC 0x200 rs2=0xA5 -> write 0xA5, o_rd_data=0; a second SC 0x200 -> no request, o_rd_data=1.
REQ-036 LR 0x200, pulse i_resv_clr, SC 0x200 -> SC fails, o_rd_data=1; LR 0x200 then SC 0x204 -> fails.
REQ-037 AMO with ack delayed 4 cycles -> address, we and wdata stable throughout, o_busy high continuously; addr 0x102 -> o_misaligned=1 one cycle after start, no o_mem_req.
REQ-038 i_rst asserted mid-WR -> o_mem_req low immediately, reservation invalid; a following ack -> no o_done.

Source files
------------

// File: rtl/riscv_core_amo_sequencer.sv
// RISC-V A-extension sequencer: LR/SC reservation and AMO read-modify-write.
// One operation in flight; o_busy stalls the pipeline until o_done.
module riscv_core_amo_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_amo,
  input  logic [3:0]      i_amo_op,
  input  logic            i_lr,
  input  logic            i_sc,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_resv_clr,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_misaligned
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic            is_amo_q;
  logic            is_sc_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] old_q;
  logic [XLEN-1:0] rd_data_q;
  logic            mis_q;
  logic            resv_valid_q;
  logic [XLEN-3:0] resv_addr_q;
  logic [XLEN-1:0] amo_res;

  logic accept;
  logic misaligned;
  logic sc_hit;

  assign accept     = (state_q == IDLE) && i_start
                   && (i_amo || i_lr || i_sc);
  assign misaligned = (i_addr[1:0] != 2'b00);
  assign sc_hit     = resv_valid_q
                   && (resv_addr_q == i_addr[XLEN-1:2]);

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: misaligned and failed SC skip memory entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned)   state_d = DONE;
          else if (i_sc)    state_d = sc_hit ? WR : DONE;
          else              state_d = RD;
        end
      end
      RD: begin
        if (i_mem_ack) state_d = is_amo_q ? WR : DONE;
      end
      WR: begin
        if (i_mem_ack) state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  // AMO combine of the old memory word with rs2 (codes 9-15 swap).
  always_comb begin
    amo_res = rs2_q;
    case (op_q)
      4'd1: amo_res = old_q + rs2_q;
      4'd2: amo_res = old_q ^ rs2_q;
      4'd3: amo_res = old_q & rs2_q;
      4'd4: amo_res = old_q | rs2_q;
      4'd5: amo_res = ($signed(old_q) < $signed(rs2_q))
                    ? old_q : rs2_q;
      4'd6: amo_res = ($signed(old_q) > $signed(rs2_q))
                    ? old_q : rs2_q;
      4'd7: amo_res = (old_q < rs2_q) ? old_q : rs2_q;
      4'd8: amo_res = (old_q > rs2_q) ? old_q : rs2_q;
      default: amo_res = rs2_q;
    endcase
  end

  // Operand capture at start, old value capture on the read ack.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      is_amo_q  <= 1'b0;
      is_sc_q   <= 1'b0;
      op_q      <= '0;
      addr_q    <= '0;
      rs2_q     <= '0;
      old_q     <= '0;
      rd_data_q <= '0;
      mis_q     <= 1'b0;
    end else begin
      if (accept) begin
        is_amo_q  <= i_amo;
        is_sc_q   <= i_sc;
        op_q      <= i_amo_op;
        addr_q    <= i_addr;
        rs2_q     <= i_rs2;
        mis_q     <= misaligned;
        rd_data_q <= (!misaligned && i_sc && !sc_hit)
                   ? XLEN'(1) : '0;
      end
      if ((state_q == RD) && i_mem_ack) begin
        old_q     <= i_mem_rdata;
        rd_data_q <= i_mem_rdata;
      end
    end
  end

  // Reservation: set by LR, dropped by any SC end or external clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      if ((state_q == RD) && i_mem_ack && !is_amo_q) begin
        resv_valid_q <= 1'b1;
        resv_addr_q  <= addr_q[XLEN-1:2];
      end
      if ((state_q == DONE) && is_sc_q && !mis_q)
        resv_valid_q <= 1'b0;
      if (i_resv_clr)
        resv_valid_q <= 1'b0;
    end
  end

  assign o_mem_req    = (state_q == RD) || (state_q == WR);
  assign o_mem_we     = (state_q == WR);
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = (state_q != WR) ? '0
                      : (is_amo_q ? amo_res : rs2_q);
  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == DONE);
  assign o_rd_data    = rd_data_q;
  assign o_misaligned = (state_q == DONE) && mis_q;

endmodule
